// File: rtl/attack_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | attack_pkg : state, phase and attack-type codes for the sequencer  |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package attack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WINDUP   = 3'd1,
    ST_ACTIVE   = 3'd2,
    ST_RECOVERY = 3'd3,
    ST_DRAIN    = 3'd4
  } state_t;

  localparam logic [1:0] PHASE_IDLE     = 2'd0;
  localparam logic [1:0] PHASE_WINDUP   = 2'd1;
  localparam logic [1:0] PHASE_ACTIVE   = 2'd2;
  localparam logic [1:0] PHASE_RECOVERY = 2'd3;

  localparam logic ATK_PUNCH = 1'b0;
  localparam logic ATK_KICK  = 1'b1;

  localparam int DEF_PUNCH_WINDUP_FRAC = 8;
  localparam int DEF_PUNCH_ACTIVE_FRAC = 4;
  localparam int DEF_KICK_WINDUP_FRAC  = 4;
  localparam int DEF_KICK_ACTIVE_FRAC  = 2;
  localparam int DEF_RECOVERY_FRAC     = 4;

  // DRAIN is invisible outside the block and reports as IDLE.
  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      ST_WINDUP:   return PHASE_WINDUP;
      ST_ACTIVE:   return PHASE_ACTIVE;
      ST_RECOVERY: return PHASE_RECOVERY;
      default:     return PHASE_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_edge_detect : rising-edge detector against a registered copy   |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module btn_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic r_btn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_q <= 1'b0;
    end else begin
      r_btn_q <= btn;
    end
  end

  assign rise = btn & ~r_btn_q;

endmodule
`default_nettype wire

// File: rtl/attack_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | attack_sequencer : punch/kick windup-active-recovery sequencer     |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
module attack_sequencer
  import attack_pkg::*;
#(
  parameter int PUNCH_WINDUP_FRAC = DEF_PUNCH_WINDUP_FRAC,
  parameter int PUNCH_ACTIVE_FRAC = DEF_PUNCH_ACTIVE_FRAC,
  parameter int KICK_WINDUP_FRAC  = DEF_KICK_WINDUP_FRAC,
  parameter int KICK_ACTIVE_FRAC  = DEF_KICK_ACTIVE_FRAC,
  parameter int RECOVERY_FRAC     = DEF_RECOVERY_FRAC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_punch,
  input  logic       btn_kick,
  input  logic       hit_stun,
  input  logic       timer_done,
  input  logic       timer_halfway,
  input  logic       timer_running,
  output logic       timer_start,
  output logic [3:0] timer_fraction,
  output logic [1:0] phase,
  output logic       attack_type,
  output logic       hitbox_active,
  output logic       busy,
  output logic       attack_done
);

  state_t r_state, w_next;
  logic   r_buf_valid, w_buf_valid;
  logic   r_buf_type, w_buf_type;
  logic   r_type, w_type;
  logic   r_start, w_start;
  logic   r_done, w_done;
  logic   r_hitbox, w_hitbox;
  logic   w_punch_rise, w_kick_rise, w_any_rise, w_rise_type;

  btn_edge_detect u_punch_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_punch),
    .rise  (w_punch_rise)
  );

  btn_edge_detect u_kick_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_kick),
    .rise  (w_kick_rise)
  );

  assign w_any_rise  = w_punch_rise | w_kick_rise;
  assign w_rise_type = w_punch_rise ? ATK_PUNCH : ATK_KICK;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_buf_valid <= 1'b0;
      r_buf_type  <= ATK_PUNCH;
      r_type      <= ATK_PUNCH;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      r_hitbox    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_buf_valid <= w_buf_valid;
      r_buf_type  <= w_buf_type;
      r_type      <= w_type;
      r_start     <= w_start;
      r_done      <= w_done;
      r_hitbox    <= w_hitbox;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_buf_valid = r_buf_valid;
    w_buf_type  = r_buf_type;
    w_type      = r_type;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_hitbox    = r_hitbox;
    case (r_state)
      ST_IDLE: begin
        if (w_any_rise && !hit_stun) begin
          w_next  = ST_WINDUP;
          w_type  = w_rise_type;
          w_start = 1'b1;
        end
      end
      ST_WINDUP: begin
        if (hit_stun) begin
          w_next = ST_DRAIN;
        end else if (timer_done) begin
          w_next   = ST_ACTIVE;
          w_start  = 1'b1;
          w_hitbox = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (hit_stun) begin
          w_next   = ST_DRAIN;
          w_hitbox = 1'b0;
        end else if (timer_done) begin
          w_next   = ST_RECOVERY;
          w_start  = 1'b1;
          w_hitbox = 1'b0;
        end else if (timer_halfway) begin
          w_hitbox = 1'b0;
        end
      end
      ST_RECOVERY: begin
        if (hit_stun) begin
          w_next      = ST_DRAIN;
          w_buf_valid = 1'b0;
        end else begin
          // First edge wins the slot; an edge in the done cycle still counts.
          if (!r_buf_valid && w_any_rise) begin
            w_buf_valid = 1'b1;
            w_buf_type  = w_rise_type;
          end
          if (timer_done) begin
            w_done = 1'b1;
            if (w_buf_valid) begin
              w_next      = ST_WINDUP;
              w_type      = w_buf_type;
              w_start     = 1'b1;
              w_buf_valid = 1'b0;
            end else begin
              w_next = ST_IDLE;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (!timer_running && !timer_done) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Fraction follows the state directly so it stays fixed for a whole phase.
  always_comb begin
    timer_fraction = 4'd0;
    case (r_state)
      ST_WINDUP:   timer_fraction = (r_type == ATK_KICK) ? 4'(KICK_WINDUP_FRAC) : 4'(PUNCH_WINDUP_FRAC);
      ST_ACTIVE:   timer_fraction = (r_type == ATK_KICK) ? 4'(KICK_ACTIVE_FRAC) : 4'(PUNCH_ACTIVE_FRAC);
      ST_RECOVERY: timer_fraction = 4'(RECOVERY_FRAC);
      default:     timer_fraction = 4'd0;
    endcase
  end

  assign timer_start   = r_start;
  assign attack_done   = r_done;
  assign hitbox_active = r_hitbox;
  assign attack_type   = r_type;
  assign phase         = phase_of(r_state);
  assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_attack_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_attack_sequencer : vectors, corner sequences and random run     |
// | Revision            : 1.0                                          |
// +--------------------------------------------------------------------+
module tb_attack_sequencer;

  logic       clk = 1'b0;
  logic       reset, btn_punch, btn_kick, hit_stun;
  logic       timer_done, timer_halfway, timer_running;
  logic       timer_start, attack_type, hitbox_active, busy, attack_done;
  logic [3:0] timer_fraction;
  logic [1:0] phase;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  attack_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .btn_punch      (btn_punch),
    .btn_kick       (btn_kick),
    .hit_stun       (hit_stun),
    .timer_done     (timer_done),
    .timer_halfway  (timer_halfway),
    .timer_running  (timer_running),
    .timer_start    (timer_start),
    .timer_fraction (timer_fraction),
    .phase          (phase),
    .attack_type    (attack_type),
    .hitbox_active  (hitbox_active),
    .busy           (busy),
    .attack_done    (attack_done)
  );

  // Shared fraction timer, CLOCK_FREQ = 64: a run lasts 64/frac cycles counting the start cycle.
  logic t_running;
  int   t_cnt, t_half;
  assign timer_running = t_running;
  assign timer_done    = t_running && (t_cnt == 1);
  assign timer_halfway = t_running && (t_cnt == t_half);

  always @(posedge clk) begin
    int n;
    if (reset) begin
      t_running <= 1'b0;
      t_cnt     <= 0;
      t_half    <= 0;
    end else if (timer_start) begin
      n = (timer_fraction == 4'd0) ? 64 : 64 / int'(timer_fraction);
      t_running <= 1'b1;
      t_cnt     <= n - 1;
      t_half    <= n / 2 + 1;
    end else if (t_running) begin
      if (t_cnt == 1) t_running <= 1'b0;
      t_cnt <= t_cnt - 1;
    end
  end

  // Reference model: m_phase 0..3 is the attack phase, m_drain marks the stun wind-down.
  int m_phase, m_buf;
  bit m_drain, m_type, m_hit, m_start, m_done, m_pq, m_kq;

  always @(posedge clk) begin
    bit pr, kr, any_r, rt, n_start, n_done;
    if (reset) begin
      m_phase = 0; m_buf = -1; m_drain = 0; m_type = 0; m_hit = 0;
      m_start = 0; m_done = 0; m_pq = 0; m_kq = 0;
    end else begin
      pr = btn_punch && !m_pq;
      kr = btn_kick && !m_kq;
      m_pq = btn_punch;
      m_kq = btn_kick;
      any_r = pr || kr;
      rt = pr ? 1'b0 : 1'b1;
      n_start = 0;
      n_done  = 0;
      if (m_drain) begin
        if (!timer_running && !timer_done) m_drain = 0;
      end else if (m_phase == 0) begin
        if (any_r && !hit_stun) begin
          m_phase = 1; m_type = rt; n_start = 1;
        end
      end else if (hit_stun) begin
        m_drain = 1; m_phase = 0; m_hit = 0; m_buf = -1;
      end else begin
        if (m_phase == 3 && any_r && m_buf < 0) m_buf = int'(rt);
        if (m_phase == 2 && timer_halfway) m_hit = 0;
        if (timer_done) begin
          if (m_phase == 3) begin
            n_done = 1;
            if (m_buf >= 0) begin
              m_phase = 1; m_type = m_buf[0]; m_buf = -1; n_start = 1;
            end else begin
              m_phase = 0;
            end
          end else begin
            m_phase = m_phase + 1;
            n_start = 1;
            m_hit = (m_phase == 2);
          end
        end
      end
      m_start = n_start;
      m_done  = n_done;
    end
  end

  function automatic logic [3:0] exp_frac(input int ph, input bit kick, input bit drain);
    if (drain) return 4'd0;
    case (ph)
      1: return kick ? 4'd4 : 4'd8;
      2: return kick ? 4'd2 : 4'd4;
      3: return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [10:0] got, exp;
    if (chk_en) begin
      exp = {m_start, exp_frac(m_phase, m_type, m_drain), 2'(m_phase), m_type, m_hit,
             (m_phase != 0) || m_drain, m_done};
      got = {timer_start, timer_fraction, phase, attack_type, hitbox_active, busy, attack_done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model_cmp t=%0t got{start,frac,phase,type,hit,busy,done}=%b required=%b",
                 $time, got, exp);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; btn_punch = 1'b0; btn_kick = 1'b0; hit_stun = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_until(input string name, input int what, input int limit);
    int  n = 0;
    bit  hit = 1'b0;
    while (n < limit && !hit) begin
      @(negedge clk);
      n++;
      case (what)
        0: hit = (busy == 1'b0);
        1: hit = (phase == 2'd2);
        2: hit = (phase == 2'd3);
        default: hit = (attack_done == 1'b1);
      endcase
    end
    check({name, "_timeout"}, 32'(hit), 32'd1);
  endtask

  typedef struct {
    int         cyc;
    logic       punch;
    logic [1:0] ph;
    logic       st;
    logic [3:0] fr;
    logic       hb;
    logic       dn;
    logic       bz;
  } vec_t;

  vec_t vt[12];

  initial begin
    int cur;
    int starts;
    int viol;

    vt[0]  = '{0,  1'b1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1,  1'b0, 2'd1, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1};
    vt[2]  = '{2,  1'b0, 2'd1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{8,  1'b0, 2'd1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{9,  1'b0, 2'd2, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1};
    vt[5]  = '{16, 1'b0, 2'd2, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1};
    vt[6]  = '{17, 1'b0, 2'd2, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1};
    vt[7]  = '{24, 1'b0, 2'd2, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{25, 1'b0, 2'd3, 1'b1, 4'd4, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{40, 1'b0, 2'd3, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1};
    vt[10] = '{41, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    vt[11] = '{42, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; btn_punch = 1'b0; btn_kick = 1'b0; hit_stun = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;

    // Table: a single punch walked through every phase boundary.
    do_reset();
    cur = 0;
    foreach (vt[i]) begin
      while (cur < vt[i].cyc) begin
        @(negedge clk);
        cur++;
      end
      check($sformatf("punch_vec_c%0d", vt[i].cyc),
            {20'd0, phase, timer_start, timer_fraction, hitbox_active, attack_done, busy, attack_type},
            {20'd0, vt[i].ph, vt[i].st, vt[i].fr, vt[i].hb, vt[i].dn, vt[i].bz, 1'b0});
      btn_punch = vt[i].punch;
    end

    // Simultaneous edges: punch wins.
    do_reset();
    btn_punch = 1'b1; btn_kick = 1'b1;
    @(negedge clk);
    check("simul_type", 32'(attack_type), 32'd0);
    check("simul_frac", 32'(timer_fraction), 32'd8);
    btn_punch = 1'b0; btn_kick = 1'b0;
    wait_until("simul_idle", 0, 100);

    // Kick buffered during recovery chains straight into a new windup.
    do_reset();
    btn_kick = 1'b1;
    @(negedge clk);
    btn_kick = 1'b0;
    wait_until("chain_rec", 2, 200);
    repeat (2) @(negedge clk);
    btn_kick = 1'b1;
    @(negedge clk);
    btn_kick = 1'b0;
    wait_until("chain_done", 3, 100);
    check("chain_phase", 32'(phase), 32'd1);
    check("chain_start", 32'(timer_start), 32'd1);
    check("chain_frac", 32'(timer_fraction), 32'd4);
    check("chain_type", 32'(attack_type), 32'd1);
    check("chain_busy", 32'(busy), 32'd1);
    wait_until("chain_idle", 0, 200);

    // Stun three cycles into active drains without a pulse or timer request.
    do_reset();
    btn_punch = 1'b1;
    @(negedge clk);
    btn_punch = 1'b0;
    wait_until("stun_act", 1, 100);
    repeat (3) @(negedge clk);
    hit_stun = 1'b1;
    @(negedge clk);
    hit_stun = 1'b0;
    check("stun_hitbox", 32'(hitbox_active), 32'd0);
    check("stun_busy", 32'(busy), 32'd1);
    viol = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      if (timer_start || attack_done) viol++;
      @(negedge clk);
    end
    check("stun_no_pulse", 32'(viol), 32'd0);
    check("stun_idle", 32'(busy), 32'd0);

    // Held button gives one attack; edge under stun gives none.
    do_reset();
    btn_punch = 1'b1;
    starts = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (timer_start && phase == 2'd1) starts++;
    end
    check("held_attacks", 32'(starts), 32'd1);
    btn_punch = 1'b0;
    hit_stun = 1'b1;
    @(negedge clk);
    btn_punch = 1'b1;
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy) viol++;
    end
    check("stun_idle_block", 32'(viol), 32'd0);
    hit_stun = 1'b0; btn_punch = 1'b0;

    // Reset during windup, then a clean restart.
    do_reset();
    btn_punch = 1'b1;
    @(negedge clk);
    btn_punch = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_outputs",
          {21'd0, timer_start, timer_fraction, phase, attack_type, hitbox_active, busy, attack_done}, 32'd0);
    btn_punch = 1'b1;
    @(negedge clk);
    check("rst_restart", {28'd0, phase, timer_start, 1'b0}, {28'd0, 2'd1, 1'b1, 1'b0});
    btn_punch = 1'b0;

    // Random traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) btn_punch = ~btn_punch;
      if ($urandom_range(0, 9) == 0) btn_kick = ~btn_kick;
      hit_stun = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 699) == 0);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
